vector_lsu: RTL and testbench

VECTOR_LSU -- requirements
Module: vector_lsu

---
 rtl/vector_lsu.sv | 169 ++++++++++++++++
 tb/tb_vector_lsu.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_lsu.sv
// vector_lsu -- unit-stride vector load/store unit with an OBI data port.
//
// A request (start) moves up to 16 bytes between a 128-bit vector register
// and memory. It issues one 32-bit OBI transaction at a time, and each
// transaction waits for its response before the next one is issued.
// Loads assemble the returned words into vreg_wdata. They then strobe
// vreg_write once, with a byte mask that covers the valid bytes.
//
// Optional feature (compile-time macro):
//   LSU_MISALIGN_CHECK_EN  reject requests whose base_addr[1:0] != 0.
//                          When the macro is not defined, the low address
//                          bits are ignored.
//
// Ports:
//   clk, n_reset                   clock, asynchronous active-low reset
//   start, store, base_addr, vl,   request; sampled only in IDLE
//   vsew, vs3_data
//   busy, done, error              status (done/error are one-cycle pulses)
//   vreg_write, vreg_wdata,        load writeback to the vector register
//   vreg_byte_en
//   data_req, data_we, data_addr,  OBI request channel
//   data_be, data_wdata, data_gnt
//   data_rvalid, data_rdata        OBI response channel
module vector_lsu (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  input  logic         store,
  input  logic [31:0]  base_addr,
  input  logic [4:0]   vl,
  input  logic [1:0]   vsew,
  input  logic [127:0] vs3_data,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         vreg_write,
  output logic [127:0] vreg_wdata,
  output logic [15:0]  vreg_byte_en,
  output logic         data_req,
  output logic         data_we,
  output logic [31:0]  data_addr,
  output logic [3:0]   data_be,
  output logic [31:0]  data_wdata,
  input  logic         data_gnt,
  input  logic         data_rvalid,
  input  logic [31:0]  data_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_WB, S_FIN} state_t;

  state_t        state_q, state_d;
  logic          store_q;
  logic [29:0]   word_base_q;   // base address in 32-bit words
  logic [4:0]    n_bytes_q;     // N, 0..16
  logic [2:0]    n_words_q;     // W, 0..4
  logic [1:0]    k_q;           // current word index
  logic [127:0]  vs3_q;
  logic          err_q;

  logic [7:0]    span;
  logic [4:0]    n_bytes_start;
  logic [4:0]    n_bytes_round;
  logic [2:0]    n_words_start;
  logic          reject;
  logic          accept;
  logic          last_word;
  logic [3:0]    be;
  logic [31:0]  be_mask;

  // Request decode. vl << vsew can reach 124 bytes, and the register holds 16.
  // NOTE: every signal written in an always_comb gets a default before any
  // conditional assignment, so no path can leave it unassigned (no latch).
  always_comb begin
    span          = {3'b000, vl} << vsew;
    n_bytes_start = (span > 8'd16) ? 5'd16 : span[4:0];
    n_bytes_round = n_bytes_start + 5'd3;
    n_words_start = n_bytes_round[4:2];
    reject        = (vsew == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
    if (base_addr[1:0] != 2'b00) reject = 1'b1;
`endif
  end

`ifndef LSU_MISALIGN_CHECK_EN
  // The low address bits are ignored in this build.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^base_addr[1:0];
`endif

  assign accept    = (state_q == S_IDLE) && start && !reject;
  assign last_word = ({1'b0, k_q} == (n_words_q - 3'd1));

  // Byte j of word k is valid when its byte index 4k+j is below N. This
  // gives 1111 for every word except a partial last word.
  always_comb begin
    be = '0;
    for (int j = 0; j < 4; j++) begin
      be[j] = ({1'b0, k_q, 2'(j)} < n_bytes_q);
    end
    be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = (n_bytes_start == 5'd0) ? S_FIN : S_REQ;
      S_REQ:  if (data_gnt) state_d = S_RESP;
      S_RESP: if (data_rvalid) begin
                if (!last_word)   state_d = S_REQ;
                else if (store_q) state_d = S_FIN;
                else              state_d = S_WB;
              end
      S_WB:   state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  // NOTE: the wide data registers are reset along with the control state.
  // This keeps all outputs at 0 while n_reset is low, vreg_wdata included.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      word_base_q <= '0;
      n_bytes_q   <= '0;
      n_words_q   <= '0;
      k_q         <= '0;
      vs3_q       <= '0;
      err_q       <= 1'b0;
      vreg_wdata  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == S_IDLE) && start && reject;
      if (accept) begin
        store_q     <= store;
        word_base_q <= base_addr[31:2];
        n_bytes_q   <= n_bytes_start;
        n_words_q   <= n_words_start;
        vs3_q       <= vs3_data;
        k_q         <= '0;
        if (!store) vreg_wdata <= '0;
      end
      if ((state_q == S_RESP) && data_rvalid) begin
        if (!store_q) vreg_wdata[{k_q, 5'd0} +: 32] <= data_rdata & be_mask;
        if (!last_word) k_q <= k_q + 2'd1;
      end
    end
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_FIN);
    error      = err_q;
    vreg_write = (state_q == S_WB);
    data_req   = (state_q == S_REQ);
    data_we    = data_req && store_q;
    data_addr  = data_req ? {word_base_q + 30'(k_q), 2'b00} : '0;
    data_be    = data_req ? be : '0;
    data_wdata = data_we ? vs3_q[{k_q, 5'd0} +: 32] : '0;
    vreg_byte_en = '0;
    for (int i = 0; i < 16; i++) begin
      vreg_byte_en[i] = vreg_write && (5'(i) < n_bytes_q);
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu. A directed vector table and a few
// hand-written sequences run first, then randomized requests follow. A
// byte-level reference model computes the expected bus traffic, latency
// and writeback data.
module tb_vector_lsu;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         start, store;
  logic [31:0]  base_addr;
  logic [4:0]   vl;
  logic [1:0]   vsew;
  logic [127:0] vs3_data;
  logic         busy, done, error, vreg_write;
  logic [127:0] vreg_wdata;
  logic [15:0]  vreg_byte_en;
  logic         data_req, data_we;
  logic [31:0]  data_addr;
  logic [3:0]   data_be;
  logic [31:0]  data_wdata;
  logic         data_gnt, data_rvalid;
  logic [31:0]  data_rdata;

  vector_lsu dut (
    .clk(clk), .n_reset(n_reset), .start(start), .store(store),
    .base_addr(base_addr), .vl(vl), .vsew(vsew), .vs3_data(vs3_data),
    .busy(busy), .done(done), .error(error), .vreg_write(vreg_write),
    .vreg_wdata(vreg_wdata), .vreg_byte_en(vreg_byte_en),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_be(data_be), .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    string       name;
    logic        st;
    logic [31:0] ba;
    logic [4:0]  vl;
    logic [1:0]  sew;
    int          stall_word;
    int          gnt_low;
    int          inj;
    int          exp_lat;
    int          exp_words;
    logic [3:0]  exp_last_be;
    logic [15:0] exp_ben;
    logic        exp_err;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Results captured by run_txn.
  int           r_lat, r_done, r_err, r_wr, r_unstable, r_req_resp;
  logic [127:0] r_wdata;
  logic [15:0]  r_ben;
  bus_t         r_bus[$];
  logic [127:0] model_vreg = '0;

  localparam logic [127:0] VS3_K = 128'h88887777_66665555_44443333_22221111;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Drives one request and acts as the OBI slave. The grant for each word
  // comes after gnt_low cycles of data_req; that is 1 normally and gnt_low
  // on stall_word. The response comes in the cycle after the grant. With
  // rst_word >= 0, reset is asserted in the response cycle of that word.
  task automatic run_txn(input logic st, input logic [31:0] ba, input logic [4:0] v,
                         input logic [1:0] sew, input logic [127:0] vs3,
                         input int stall_word, input int gnt_low, input int inj,
                         input int rst_word);
    int   seen, word, tail, rst_cyc;
    bit   resp_now;
    bus_t cur;
    r_lat = -1; r_done = 0; r_err = 0; r_wr = 0; r_unstable = 0; r_req_resp = 0;
    r_wdata = '0; r_ben = '0; r_bus.delete();
    seen = 0; word = 0; tail = 0; rst_cyc = 0; resp_now = 0;
    cur = '{32'h0, 4'h0, 1'b0, 32'h0};
    @(negedge clk);
    start = 1'b1; store = st; base_addr = ba; vl = v; vsew = sew; vs3_data = vs3;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = (cyc == inj);
      if (start) begin
        store = ~st; base_addr = 32'hDEAD_0000; vl = 5'd4; vsew = 2'b00; vs3_data = '1;
      end
      data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        n_reset = 1'b1;
        data_rvalid = 1'b1;          // late response after the reset
        data_rdata = 32'hFFFF_FFFF;
      end
      if (done) begin r_done++; if (r_lat < 0) r_lat = cyc; end
      if (error) r_err++;
      if (vreg_write) begin r_wr++; r_wdata = vreg_wdata; r_ben = vreg_byte_en; end
      if (rst_cyc == 0) begin
        if (resp_now) begin
          resp_now = 0;
          if (data_req) r_req_resp++;
          if (word == rst_word) begin
            n_reset = 1'b0;
            rst_cyc = cyc;
            #1;
            check("rst.outputs", {busy, done, error, vreg_write, vreg_byte_en, data_req,
                                  data_we, data_addr, data_be, data_wdata}, '0);
            check("rst.vreg_wdata", vreg_wdata, '0);
          end else begin
            data_rvalid = 1'b1;
            data_rdata = rd_val(cur.addr);
            word++;
          end
        end else if (data_req) begin
          if (seen == 0) begin
            cur.addr = data_addr; cur.be = data_be; cur.we = data_we; cur.wdata = data_wdata;
            r_bus.push_back(cur);
          end else if ({data_addr, data_be, data_we, data_wdata} !=
                       {cur.addr, cur.be, cur.we, cur.wdata}) begin
            r_unstable++;
          end
          seen++;
          if (seen > ((word == stall_word) ? gnt_low : 1)) begin
            data_gnt = 1'b1;
            seen = 0;
            resp_now = 1;
          end
        end
      end
      if (r_done > 0 || r_err > 0 || rst_cyc > 0) begin
        tail++;
        if (tail > 4) break;
      end
    end
    start = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0; n_reset = 1'b1;
  endtask

  // Reference model: works directly from byte counts and byte addresses.
  task automatic verify(input string tag, input logic st, input logic [31:0] ba,
                        input logic [4:0] v, input logic [1:0] sew, input logic [127:0] vs3,
                        input int stall_word, input int gnt_low);
    bit           rej;
    int           nb, w, extra, lat;
    logic [31:0]  wa, wv;
    logic [127:0] exp_v;
    rej = (sew == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
    if (ba[1:0] != 2'b00) rej = 1;
`endif
    nb = rej ? 0 : int'(v) * (1 << sew);
    if (nb > 16) nb = 16;
    w = (nb + 3) / 4;
    extra = (stall_word >= 0 && stall_word < w) ? gnt_low - 1 : 0;
    if (rej) lat = -1;
    else if (nb == 0) lat = 1;
    else lat = 3 * w + (st ? 1 : 2) + extra;
    exp_v = '0;
    for (int i = 0; i < nb; i++) begin
      wa = (ba & ~32'h3) + 32'(4 * (i / 4));
      wv = rd_val(wa);
      exp_v[8*i +: 8] = wv[8*(i%4) +: 8];
    end
    check({tag, ".error"}, 128'(r_err), 128'(rej ? 1 : 0));
    check({tag, ".done"}, 128'(r_done), 128'(rej ? 0 : 1));
    check({tag, ".latency"}, 128'(r_lat), 128'(lat));
    check({tag, ".words"}, 128'(r_bus.size()), 128'(w));
    for (int k = 0; k < w && k < r_bus.size(); k++) begin
      check($sformatf("%s.addr%0d", tag, k), 128'(r_bus[k].addr), 128'((ba & ~32'h3) + 32'(4 * k)));
      wv = '0;
      for (int j = 0; j < 4; j++) wv[j] = (4 * k + j < nb);
      check($sformatf("%s.be%0d", tag, k), 128'(r_bus[k].be), 128'(wv[3:0]));
      check($sformatf("%s.we%0d", tag, k), 128'(r_bus[k].we), 128'(st));
      if (st) check($sformatf("%s.wdata%0d", tag, k), 128'(r_bus[k].wdata), 128'(vs3[32*k +: 32]));
    end
    check({tag, ".vreg_write"}, 128'(r_wr), 128'((!rej && !st && nb > 0) ? 1 : 0));
    if (!rej && !st && nb > 0) begin
      check({tag, ".vreg_wdata"}, r_wdata, exp_v);
      check({tag, ".byte_en"}, 128'(r_ben), 128'((17'h1 << nb) - 17'h1));
    end
    if (!rej && !st) model_vreg = exp_v;
    check({tag, ".vreg_hold"}, vreg_wdata, model_vreg);
    check({tag, ".stable"}, 128'(r_unstable), '0);
    check({tag, ".req_in_resp"}, 128'(r_req_resp), '0);
    check({tag, ".busy_end"}, 128'(busy), '0);
  endtask

  vec_t tbl[9];

  initial begin
    n_reset = 1'b0; start = 1'b0; store = 1'b0; base_addr = '0; vl = '0; vsew = '0;
    vs3_data = '0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset.outputs", {busy, done, error, vreg_write, vreg_byte_en, data_req,
                            data_we, data_addr, data_be, data_wdata}, '0);
    check("reset.vreg_wdata", vreg_wdata, '0);
    n_reset = 1'b1;

    //            name          st    base          vl     sew   stw gl inj lat wds lastbe  ben       err
    tbl[0] = '{"unit_load",   1'b0, 32'h0000_0100, 5'd8,  2'd1, -1, 1, -1, 14, 4, 4'hF, 16'hFFFF, 1'b0};
    tbl[1] = '{"partial",     1'b0, 32'h0000_0200, 5'd5,  2'd0, -1, 1, -1,  8, 2, 4'h1, 16'h001F, 1'b0};
    tbl[2] = '{"store3",      1'b1, 32'h0000_0300, 5'd3,  2'd2, -1, 1, -1, 10, 3, 4'hF, 16'h0000, 1'b0};
    tbl[3] = '{"vl_zero",     1'b0, 32'h0000_0400, 5'd0,  2'd1, -1, 1, -1,  1, 0, 4'h0, 16'h0000, 1'b0};
    tbl[4] = '{"vsew_rsvd",   1'b0, 32'h0000_0400, 5'd4,  2'd3, -1, 1, -1, -1, 0, 4'h0, 16'h0000, 1'b1};
`ifdef LSU_MISALIGN_CHECK_EN
    tbl[5] = '{"misalign",    1'b0, 32'h0000_0102, 5'd4,  2'd2, -1, 1, -1, -1, 0, 4'h0, 16'h0000, 1'b1};
`else
    tbl[5] = '{"misalign",    1'b0, 32'h0000_0102, 5'd4,  2'd2, -1, 1, -1, 14, 4, 4'hF, 16'hFFFF, 1'b0};
`endif
    tbl[6] = '{"store_clamp", 1'b1, 32'h0000_0040, 5'd31, 2'd2, -1, 1, -1, 13, 4, 4'hF, 16'h0000, 1'b0};
    tbl[7] = '{"load_6b",     1'b0, 32'h0000_0700, 5'd3,  2'd1, -1, 1, -1,  8, 2, 4'h3, 16'h003F, 1'b0};
    tbl[8] = '{"gnt_stall",   1'b1, 32'h0000_0600, 5'd4,  2'd2,  1, 5,  6, 17, 4, 4'hF, 16'h0000, 1'b0};

    for (int t = 0; t < 9; t++) begin
      run_txn(tbl[t].st, tbl[t].ba, tbl[t].vl, tbl[t].sew, VS3_K,
              tbl[t].stall_word, tbl[t].gnt_low, tbl[t].inj, -1);
      check({tbl[t].name, ".tbl_error"}, 128'(r_err), 128'(tbl[t].exp_err));
      check({tbl[t].name, ".tbl_latency"}, 128'(r_lat), 128'(tbl[t].exp_lat));
      check({tbl[t].name, ".tbl_words"}, 128'(r_bus.size()), 128'(tbl[t].exp_words));
      check({tbl[t].name, ".tbl_byte_en"}, 128'(r_ben), 128'(tbl[t].exp_ben));
      if (tbl[t].exp_words > 0 && r_bus.size() == tbl[t].exp_words)
        check({tbl[t].name, ".tbl_last_be"}, 128'(r_bus[tbl[t].exp_words-1].be), 128'(tbl[t].exp_last_be));
      verify(tbl[t].name, tbl[t].st, tbl[t].ba, tbl[t].vl, tbl[t].sew, VS3_K,
             tbl[t].stall_word, tbl[t].gnt_low);
    end

    // Store data of the first words, written out by hand.
    run_txn(1'b1, 32'h0000_0800, 5'd3, 2'd2, VS3_K, -1, 1, -1, -1);
    if (r_bus.size() == 3) begin
      check("store.w0", 128'(r_bus[0].wdata), 128'(32'h2222_1111));
      check("store.w1", 128'(r_bus[1].wdata), 128'(32'h4444_3333));
      check("store.w2", 128'(r_bus[2].wdata), 128'(32'h6666_5555));
    end else begin
      check("store.count", 128'(r_bus.size()), 128'(3));
    end

    // Reset in the response phase of word 2, then a normal load.
    run_txn(1'b0, 32'h0000_0500, 5'd16, 2'd1, VS3_K, -1, 1, -1, 2);
    model_vreg = '0;
    check("rst.done", 128'(r_done), '0);
    check("rst.vreg_write", 128'(r_wr), '0);
    check("rst.words", 128'(r_bus.size()), 128'(3));
    check("rst.busy_after", 128'(busy), '0);
    check("rst.vreg_after", vreg_wdata, '0);
    run_txn(1'b0, 32'h0000_0900, 5'd8, 2'd1, VS3_K, -1, 1, -1, -1);
    verify("rst.recover", 1'b0, 32'h0000_0900, 5'd8, 2'd1, VS3_K, -1, 1);

    // Randomized requests.
    for (int r = 0; r < 40; r++) begin
      logic         st;
      logic [31:0]  ba;
      logic [4:0]   v;
      logic [1:0]   sew;
      logic [127:0] vs3;
      int           sw, gl;
      st  = 1'($urandom_range(0, 1));
      ba  = $urandom;
      v   = 5'($urandom_range(0, 31));
      sew = 2'($urandom_range(0, 3));
      vs3 = {$urandom, $urandom, $urandom, $urandom};
      sw  = $urandom_range(0, 3);
      gl  = $urandom_range(1, 3);
      run_txn(st, ba, v, sew, vs3, sw, gl, -1, -1);
      verify($sformatf("rand%0d", r), st, ba, v, sew, vs3, sw, gl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
